// File: rtl/control_unit.sv
// control_unit: hardwired Mini-SRC control sequencer, T0..T7 step FSM with a Moore strobe decode of (state, op_r).
// Optional macro CU_ILLEGAL_TRAP_EN: opcodes 11100-11111 halt the sequencer and set illegal_op instead of acting as nop.
module control_unit #(
    parameter logic [4:0] ADD_OP  = 5'b00011,
    parameter logic [4:0] HALT_OP = 5'b11011
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [4:0] opcode,
    input  logic       con_ff,
    input  logic       mem_done,
    input  logic       stop,
    output logic       pc_out,
    output logic       mar_in,
    output logic       inc_pc,
    output logic       z_in,
    output logic       z_lo_out,
    output logic       z_hi_out,
    output logic       pc_in,
    output logic       mdr_in,
    output logic       mdr_out,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_in,
    output logic       gra,
    output logic       grb,
    output logic       grc,
    output logic       r_in,
    output logic       r_out,
    output logic       ba_out,
    output logic       c_out,
    output logic       y_in,
    output logic       hi_in,
    output logic       lo_in,
    output logic       hi_out,
    output logic       lo_out,
    output logic       in_port_out,
    output logic       out_port_in,
    output logic       con_in,
    output logic [4:0] alu_op,
`ifdef CU_ILLEGAL_TRAP_EN
    output logic       illegal_op,
`endif
    output logic       run
);

    typedef enum logic [3:0] {
        S_RST  = 4'd0, S_T0 = 4'd1, S_T1 = 4'd2, S_T2 = 4'd3, S_T3 = 4'd4,
        S_T4   = 4'd5, S_T5 = 4'd6, S_T6 = 4'd7, S_T7 = 4'd8, S_HALT = 4'd9
    } state_t;

    typedef enum logic [4:0] {
        C_LD, C_LDI, C_ST, C_ALU_REG, C_ALU_IMM, C_MULDIV, C_NEGNOT, C_BR, C_JR,
        C_JAL, C_IN, C_OUT, C_MFHI, C_MFLO, C_NOP, C_HALT, C_ILL
    } op_class_t;

    function automatic op_class_t classify(input logic [4:0] op);
        op_class_t cls;
        if (op == HALT_OP) begin
            cls = C_HALT;
        end else begin
            case (op)
                5'd0:                                   cls = C_LD;
                5'd1:                                   cls = C_LDI;
                5'd2:                                   cls = C_ST;
                5'd3, 5'd4, 5'd5, 5'd6, 5'd7,
                5'd8, 5'd9, 5'd10, 5'd11:               cls = C_ALU_REG;
                5'd12, 5'd13, 5'd14:                    cls = C_ALU_IMM;
                5'd15, 5'd16:                           cls = C_MULDIV;
                5'd17, 5'd18:                           cls = C_NEGNOT;
                5'd19:                                  cls = C_BR;
                5'd20:                                  cls = C_JR;
                5'd21:                                  cls = C_JAL;
                5'd22:                                  cls = C_IN;
                5'd23:                                  cls = C_OUT;
                5'd24:                                  cls = C_MFHI;
                5'd25:                                  cls = C_MFLO;
                5'd26:                                  cls = C_NOP;
                default:                                cls = C_ILL;
            endcase
        end
        return cls;
    endfunction

    function automatic state_t last_step(input op_class_t cls);
        state_t s;
        case (cls)
            C_ALU_REG, C_ALU_IMM, C_LDI: s = S_T5;
            C_MULDIV, C_BR:              s = S_T6;
            C_NEGNOT, C_JAL:             s = S_T4;
            C_LD, C_ST:                  s = S_T7;
            default:                     s = S_T3;
        endcase
        return s;
    endfunction

    function automatic state_t next_step(input state_t s);
        state_t n;
        case (s)
            S_T3:    n = S_T4;
            S_T4:    n = S_T5;
            S_T5:    n = S_T6;
            S_T6:    n = S_T7;
            default: n = S_T0;
        endcase
        return n;
    endfunction

    state_t     state_r, state_s, boundary_s;
    logic [4:0] op_r;
    logic       t1_seen_r;
    logic       hold_s;
    op_class_t  op_cls_s, dec_cls_s;

    assign op_cls_s  = classify(op_r);
    assign dec_cls_s = classify(opcode);
    assign hold_s    = !mem_done && (((state_r == S_T6) && (op_cls_s == C_LD)) ||
                                     ((state_r == S_T7) && (op_cls_s == C_ST)));

    // State, latched opcode and first-T1-cycle tracking.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= S_RST;
            op_r      <= 5'd0;
            t1_seen_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            t1_seen_r <= (state_r == S_T1);
            if (state_r == S_T2) begin
                op_r <= opcode;
            end
        end
    end

    // Next-state: fetch steps, T2 dispatch, execute steps and the instruction boundary.
    always_comb begin
        state_s    = state_r;
        boundary_s = stop ? S_HALT : S_T0;
        case (state_r)
            S_RST:  state_s = S_T0;
            S_T0:   state_s = S_T1;
            S_T1:   state_s = mem_done ? S_T2 : S_T1;
            S_T2: begin
                case (dec_cls_s)
                    C_NOP:  state_s = boundary_s;
                    C_HALT: state_s = S_HALT;
                    C_ILL: begin
`ifdef CU_ILLEGAL_TRAP_EN
                        state_s = S_HALT;
`else
                        state_s = boundary_s;
`endif
                    end
                    default: state_s = S_T3;
                endcase
            end
            S_T3, S_T4, S_T5, S_T6, S_T7: begin
                if (hold_s) begin
                    state_s = state_r;
                end else if (state_r == last_step(op_cls_s)) begin
                    state_s = boundary_s;
                end else begin
                    state_s = next_step(state_r);
                end
            end
            S_HALT:  state_s = S_HALT;
            default: state_s = S_RST;
        endcase
    end

    // Moore strobe decode; the T1 pc_in pulse and the branch pc_in are the only qualified strobes.
    always_comb begin
        pc_out = 1'b0; mar_in = 1'b0; inc_pc = 1'b0; z_in = 1'b0; z_lo_out = 1'b0;
        z_hi_out = 1'b0; pc_in = 1'b0; mdr_in = 1'b0; mdr_out = 1'b0; mem_read = 1'b0;
        mem_write = 1'b0; ir_in = 1'b0; gra = 1'b0; grb = 1'b0; grc = 1'b0; r_in = 1'b0;
        r_out = 1'b0; ba_out = 1'b0; c_out = 1'b0; y_in = 1'b0; hi_in = 1'b0; lo_in = 1'b0;
        hi_out = 1'b0; lo_out = 1'b0; in_port_out = 1'b0; out_port_in = 1'b0; con_in = 1'b0;
        alu_op = 5'd0;
        run    = (state_r != S_RST) && (state_r != S_HALT);
        case (state_r)
            S_T0: begin pc_out = 1'b1; mar_in = 1'b1; inc_pc = 1'b1; z_in = 1'b1; end
            S_T1: begin z_lo_out = 1'b1; pc_in = !t1_seen_r; mem_read = 1'b1; mdr_in = 1'b1; end
            S_T2: begin mdr_out = 1'b1; ir_in = 1'b1; end
            S_T3: begin
                case (op_cls_s)
                    C_ALU_REG, C_ALU_IMM: begin grb = 1'b1; r_out = 1'b1; y_in = 1'b1; end
                    C_MULDIV: begin gra = 1'b1; r_out = 1'b1; y_in = 1'b1; end
                    C_NEGNOT: begin grb = 1'b1; r_out = 1'b1; alu_op = op_r; z_in = 1'b1; end
                    C_LD, C_LDI, C_ST: begin grb = 1'b1; ba_out = 1'b1; y_in = 1'b1; end
                    C_BR:   begin gra = 1'b1; r_out = 1'b1; con_in = 1'b1; end
                    C_JR:   begin gra = 1'b1; r_out = 1'b1; pc_in = 1'b1; end
                    C_JAL:  begin pc_out = 1'b1; grb = 1'b1; r_in = 1'b1; end
                    C_IN:   begin in_port_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
                    C_OUT:  begin gra = 1'b1; r_out = 1'b1; out_port_in = 1'b1; end
                    C_MFHI: begin hi_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
                    C_MFLO: begin lo_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
                    default: begin end
                endcase
            end
            S_T4: begin
                case (op_cls_s)
                    C_ALU_REG: begin grc = 1'b1; r_out = 1'b1; alu_op = op_r; z_in = 1'b1; end
                    C_ALU_IMM: begin c_out = 1'b1; alu_op = op_r; z_in = 1'b1; end
                    C_MULDIV:  begin grb = 1'b1; r_out = 1'b1; alu_op = op_r; z_in = 1'b1; end
                    C_NEGNOT:  begin z_lo_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
                    C_LD, C_LDI, C_ST: begin c_out = 1'b1; alu_op = ADD_OP; z_in = 1'b1; end
                    C_BR:      begin pc_out = 1'b1; y_in = 1'b1; end
                    C_JAL:     begin gra = 1'b1; r_out = 1'b1; pc_in = 1'b1; end
                    default: begin end
                endcase
            end
            S_T5: begin
                case (op_cls_s)
                    C_ALU_REG, C_ALU_IMM, C_LDI: begin z_lo_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
                    C_MULDIV:   begin z_lo_out = 1'b1; lo_in = 1'b1; end
                    C_LD, C_ST: begin z_lo_out = 1'b1; mar_in = 1'b1; end
                    C_BR:       begin c_out = 1'b1; alu_op = ADD_OP; z_in = 1'b1; end
                    default: begin end
                endcase
            end
            S_T6: begin
                case (op_cls_s)
                    C_MULDIV: begin z_hi_out = 1'b1; hi_in = 1'b1; end
                    C_LD:     begin mem_read = 1'b1; mdr_in = 1'b1; end
                    C_ST:     begin gra = 1'b1; r_out = 1'b1; mdr_in = 1'b1; end
                    C_BR:     begin z_lo_out = 1'b1; pc_in = con_ff; end
                    default: begin end
                endcase
            end
            S_T7: begin
                case (op_cls_s)
                    C_LD: begin mdr_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
                    C_ST: begin mdr_out = 1'b1; mem_write = 1'b1; end
                    default: begin end
                endcase
            end
            default: begin end
        endcase
    end

`ifdef CU_ILLEGAL_TRAP_EN
    logic illegal_r;

    // Sticky record of an illegal opcode reaching dispatch; only reset clears it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            illegal_r <= 1'b0;
        end else if ((state_r == S_T2) && (dec_cls_s == C_ILL)) begin
            illegal_r <= 1'b1;
        end
    end

    assign illegal_op = illegal_r;
`endif

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: table-driven and randomized self-checking bench for control_unit.
// The random phase compares every cycle against a per-instruction micro-step list built from the instruction set.
module tb_control_unit;

    logic       clock = 1'b0;
    logic       reset_n, con_ff, mem_done, stop;
    logic [4:0] opcode;
    logic pc_out, mar_in, inc_pc, z_in, z_lo_out, z_hi_out, pc_in, mdr_in, mdr_out, mem_read;
    logic mem_write, ir_in, gra, grb, grc, r_in, r_out, ba_out, c_out, y_in, hi_in, lo_in;
    logic hi_out, lo_out, in_port_out, out_port_in, con_in, run;
    logic [4:0] alu_op;
`ifdef CU_ILLEGAL_TRAP_EN
    logic illegal_op;
`endif

    control_unit dut (
        .clock(clock), .reset_n(reset_n), .opcode(opcode), .con_ff(con_ff),
        .mem_done(mem_done), .stop(stop), .pc_out(pc_out), .mar_in(mar_in),
        .inc_pc(inc_pc), .z_in(z_in), .z_lo_out(z_lo_out), .z_hi_out(z_hi_out),
        .pc_in(pc_in), .mdr_in(mdr_in), .mdr_out(mdr_out), .mem_read(mem_read),
        .mem_write(mem_write), .ir_in(ir_in), .gra(gra), .grb(grb), .grc(grc),
        .r_in(r_in), .r_out(r_out), .ba_out(ba_out), .c_out(c_out), .y_in(y_in),
        .hi_in(hi_in), .lo_in(lo_in), .hi_out(hi_out), .lo_out(lo_out),
        .in_port_out(in_port_out), .out_port_in(out_port_in), .con_in(con_in),
        .alu_op(alu_op),
`ifdef CU_ILLEGAL_TRAP_EN
        .illegal_op(illegal_op),
`endif
        .run(run)
    );

    always #5 clock = ~clock;

    localparam logic [32:0] PC_OUT = 33'd1 << 0,  MAR_IN = 33'd1 << 1,  INC_PC = 33'd1 << 2;
    localparam logic [32:0] Z_IN = 33'd1 << 3,    Z_LO_OUT = 33'd1 << 4, Z_HI_OUT = 33'd1 << 5;
    localparam logic [32:0] PC_IN = 33'd1 << 6,   MDR_IN = 33'd1 << 7,  MDR_OUT = 33'd1 << 8;
    localparam logic [32:0] MEM_READ = 33'd1 << 9, MEM_WRITE = 33'd1 << 10, IR_IN = 33'd1 << 11;
    localparam logic [32:0] GRA = 33'd1 << 12,    GRB = 33'd1 << 13,    GRC = 33'd1 << 14;
    localparam logic [32:0] R_IN = 33'd1 << 15,   R_OUT = 33'd1 << 16,  BA_OUT = 33'd1 << 17;
    localparam logic [32:0] C_OUT = 33'd1 << 18,  Y_IN = 33'd1 << 19,   HI_IN = 33'd1 << 20;
    localparam logic [32:0] LO_IN = 33'd1 << 21,  HI_OUT = 33'd1 << 22, LO_OUT = 33'd1 << 23;
    localparam logic [32:0] IN_PORT_OUT = 33'd1 << 24, OUT_PORT_IN = 33'd1 << 25, CON_IN = 33'd1 << 26;
    localparam logic [32:0] RUN = 33'd1 << 27;
    localparam logic [32:0] T0V = PC_OUT | MAR_IN | INC_PC | Z_IN | RUN;
    localparam logic [4:0]  ADD = 5'b00011;
    localparam logic [4:0]  HALT = 5'b11011;

    function automatic logic [32:0] alu_v(input logic [4:0] op);
        return {op, 28'd0};
    endfunction

    function automatic logic [32:0] sample();
        return {alu_op, run, con_in, out_port_in, in_port_out, lo_out, hi_out, lo_in, hi_in,
                y_in, c_out, ba_out, r_out, r_in, grc, grb, gra, ir_in, mem_write, mem_read,
                mdr_out, mdr_in, pc_in, z_hi_out, z_lo_out, z_in, inc_pc, mar_in, pc_out};
    endfunction

    int checks = 0;
    int failures = 0;
    logic [32:0] cur;
    logic [32:0] trace [0:63];

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Advance to the next cycle, drive that cycle's inputs, then sample away from the rising edge.
    task automatic tick(input logic md, input logic cf);
        @(negedge clock);
        mem_done = md;
        con_ff   = cf;
        #1;
        cur = sample();
    endtask

    // Run one instruction from an already-sampled T0; trace[] gets each cycle, n is the cycle count.
    task automatic measure(input logic [4:0] op, input logic cf, input int lo_start, input int lo_len,
                           output int n);
        opcode   = op;
        trace[0] = cur;
        n = 1;
        for (int k = 1; k < 40; k++) begin
            tick(!((k >= lo_start) && (k < lo_start + lo_len)), cf);
            if (cur[2]) break;
            trace[k] = cur;
            n++;
        end
    endtask

    typedef struct {
        logic [32:0] vec;
        bit          wait_mem;
        int          kind;      // 1: fetch read (pc_in first cycle only), 2: branch target (pc_in = con_ff)
    } step_t;
    step_t q[$];

    task automatic push(input logic [32:0] v, input bit w, input int kind);
        step_t s;
        s.vec = v | RUN; s.wait_mem = w; s.kind = kind;
        q.push_back(s);
    endtask

    // Micro-step list for one instruction, written straight from the instruction descriptions.
    task automatic build(input logic [4:0] op);
        q.delete();
        push(PC_OUT | MAR_IN | INC_PC | Z_IN, 1'b0, 0);
        push(Z_LO_OUT | PC_IN | MEM_READ | MDR_IN, 1'b1, 1);
        push(MDR_OUT | IR_IN, 1'b0, 0);
        if (op >= 5'd3 && op <= 5'd14) begin
            push(GRB | R_OUT | Y_IN, 1'b0, 0);
            push(((op <= 5'd11) ? (GRC | R_OUT) : C_OUT) | alu_v(op) | Z_IN, 1'b0, 0);
            push(Z_LO_OUT | GRA | R_IN, 1'b0, 0);
        end else if (op == 5'd15 || op == 5'd16) begin
            push(GRA | R_OUT | Y_IN, 1'b0, 0);
            push(GRB | R_OUT | alu_v(op) | Z_IN, 1'b0, 0);
            push(Z_LO_OUT | LO_IN, 1'b0, 0);
            push(Z_HI_OUT | HI_IN, 1'b0, 0);
        end else if (op == 5'd17 || op == 5'd18) begin
            push(GRB | R_OUT | alu_v(op) | Z_IN, 1'b0, 0);
            push(Z_LO_OUT | GRA | R_IN, 1'b0, 0);
        end else if (op <= 5'd2) begin
            push(GRB | BA_OUT | Y_IN, 1'b0, 0);
            push(C_OUT | alu_v(ADD) | Z_IN, 1'b0, 0);
            if (op == 5'd1) begin
                push(Z_LO_OUT | GRA | R_IN, 1'b0, 0);
            end else if (op == 5'd0) begin
                push(Z_LO_OUT | MAR_IN, 1'b0, 0);
                push(MEM_READ | MDR_IN, 1'b1, 0);
                push(MDR_OUT | GRA | R_IN, 1'b0, 0);
            end else begin
                push(Z_LO_OUT | MAR_IN, 1'b0, 0);
                push(GRA | R_OUT | MDR_IN, 1'b0, 0);
                push(MDR_OUT | MEM_WRITE, 1'b1, 0);
            end
        end else begin
            case (op)
                5'd19: begin
                    push(GRA | R_OUT | CON_IN, 1'b0, 0);
                    push(PC_OUT | Y_IN, 1'b0, 0);
                    push(C_OUT | alu_v(ADD) | Z_IN, 1'b0, 0);
                    push(Z_LO_OUT, 1'b0, 2);
                end
                5'd20: push(GRA | R_OUT | PC_IN, 1'b0, 0);
                5'd21: begin
                    push(PC_OUT | GRB | R_IN, 1'b0, 0);
                    push(GRA | R_OUT | PC_IN, 1'b0, 0);
                end
                5'd22: push(IN_PORT_OUT | GRA | R_IN, 1'b0, 0);
                5'd23: push(GRA | R_OUT | OUT_PORT_IN, 1'b0, 0);
                5'd24: push(HI_OUT | GRA | R_IN, 1'b0, 0);
                5'd25: push(LO_OUT | GRA | R_IN, 1'b0, 0);
                default: begin end
            endcase
        end
    endtask

    // Walk the micro-step list under random mem_done/con_ff, ending with the next T0 sampled.
    task automatic model_instr(input logic [4:0] op);
        logic [32:0] exp;
        step_t s;
        int guard = 0;
        build(op);
        while (q.size() > 0) begin
            s   = q[0];
            exp = s.vec | ((s.kind == 2 && con_ff) ? PC_IN : 33'd0);
            check($sformatf("model op=%b", op), cur, exp);
            if (s.wait_mem && !mem_done && guard < 40) begin
                s.vec = s.vec & ~PC_IN;
                q[0]  = s;
                guard++;
            end else begin
                void'(q.pop_front());
            end
            tick($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("reset_drop", sample(), 33'd0);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        check("reset_rst_state", sample(), 33'd0);
        tick(1'b1, 1'b0);
        check("reset_first_t0", cur, T0V);
    endtask

    typedef struct {
        logic [4:0]  op;
        logic        cf;
        int          cycles;
        int          probe;
        logic [32:0] vec;
    } vec_t;
    vec_t tbl[$];

    initial begin
        #1000000;
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end

    initial begin
        int n, cnt;
        logic [4:0] op;

        tbl.push_back('{5'b00011, 1'b0, 6, 0, PC_OUT | MAR_IN | INC_PC | Z_IN});
        tbl.push_back('{5'b00011, 1'b0, 6, 1, Z_LO_OUT | PC_IN | MEM_READ | MDR_IN});
        tbl.push_back('{5'b00011, 1'b0, 6, 4, GRC | R_OUT | alu_v(5'b00011) | Z_IN});
        tbl.push_back('{5'b00011, 1'b0, 6, 5, Z_LO_OUT | GRA | R_IN});
        tbl.push_back('{5'b00100, 1'b0, 6, 3, GRB | R_OUT | Y_IN});
        tbl.push_back('{5'b11010, 1'b0, 3, 2, MDR_OUT | IR_IN});
        tbl.push_back('{5'b00000, 1'b0, 8, 7, MDR_OUT | GRA | R_IN});
        tbl.push_back('{5'b00001, 1'b0, 6, 5, Z_LO_OUT | GRA | R_IN});
        tbl.push_back('{5'b00010, 1'b0, 8, 6, GRA | R_OUT | MDR_IN});
        tbl.push_back('{5'b10011, 1'b0, 7, 5, C_OUT | alu_v(5'b00011) | Z_IN});
        tbl.push_back('{5'b10011, 1'b0, 7, 6, Z_LO_OUT});
        tbl.push_back('{5'b10011, 1'b1, 7, 6, Z_LO_OUT | PC_IN});
        tbl.push_back('{5'b01100, 1'b0, 6, 4, C_OUT | alu_v(5'b01100) | Z_IN});
        tbl.push_back('{5'b01111, 1'b0, 7, 6, Z_HI_OUT | HI_IN});
        tbl.push_back('{5'b10000, 1'b0, 7, 5, Z_LO_OUT | LO_IN});
        tbl.push_back('{5'b10010, 1'b0, 5, 3, GRB | R_OUT | alu_v(5'b10010) | Z_IN});
        tbl.push_back('{5'b10001, 1'b0, 5, 4, Z_LO_OUT | GRA | R_IN});
        tbl.push_back('{5'b10100, 1'b0, 4, 3, GRA | R_OUT | PC_IN});
        tbl.push_back('{5'b10101, 1'b0, 5, 3, PC_OUT | GRB | R_IN});
        tbl.push_back('{5'b10101, 1'b0, 5, 4, GRA | R_OUT | PC_IN});
        tbl.push_back('{5'b10110, 1'b0, 4, 3, IN_PORT_OUT | GRA | R_IN});
        tbl.push_back('{5'b10111, 1'b0, 4, 3, GRA | R_OUT | OUT_PORT_IN});
        tbl.push_back('{5'b11000, 1'b0, 4, 3, HI_OUT | GRA | R_IN});
        tbl.push_back('{5'b11001, 1'b0, 4, 3, LO_OUT | GRA | R_IN});
`ifndef CU_ILLEGAL_TRAP_EN
        tbl.push_back('{5'b11110, 1'b0, 3, 2, MDR_OUT | IR_IN});
`endif

        reset_n = 1'b0; opcode = 5'b00011; con_ff = 1'b0; mem_done = 1'b1; stop = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            #1;
            check("reset_outputs_zero", sample(), 33'd0);
        end
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        check("release_still_rst", sample(), 33'd0);
        tick(1'b1, 1'b0);
        check("first_t0", cur, T0V);

        foreach (tbl[i]) begin
            measure(tbl[i].op, tbl[i].cf, 99, 0, n);
            check_int($sformatf("cycles op=%b", tbl[i].op), n, tbl[i].cycles);
            check($sformatf("step%0d op=%b", tbl[i].probe, tbl[i].op), trace[tbl[i].probe], tbl[i].vec | RUN);
        end

        // ld stalled three cycles in T6.
        measure(5'b00000, 1'b0, 6, 3, n);
        check_int("ld_stall_cycles", n, 11);
        cnt = 0;
        for (int k = 3; k < n; k++) if (trace[k] == (MEM_READ | MDR_IN | RUN)) cnt++;
        check_int("ld_stall_read_cycles", cnt, 4);
        check("ld_stall_t7", trace[10], MDR_OUT | GRA | R_IN | RUN);

        // add stalled two cycles in T1: pc_in only on the first T1 cycle.
        measure(5'b00011, 1'b0, 1, 2, n);
        check_int("t1_stall_cycles", n, 8);
        check("t1_first", trace[1], Z_LO_OUT | PC_IN | MEM_READ | MDR_IN | RUN);
        check("t1_held", trace[2], Z_LO_OUT | MEM_READ | MDR_IN | RUN);

        for (int i = 0; i < 150; i++) begin
            op = 5'($urandom_range(0, 31));
            if (op == HALT) op = 5'd26;
`ifdef CU_ILLEGAL_TRAP_EN
            if (op > HALT) op = 5'd26;
`endif
            opcode = op;
            model_instr(op);
        end
        check("random_end_t0", cur, T0V);

        // stop at the instruction boundary.
        opcode = 5'b00011;
        stop   = 1'b1;
        for (int k = 1; k <= 5; k++) tick(1'b1, 1'b0);
        check("stop_last_step", cur, Z_LO_OUT | GRA | R_IN | RUN);
        tick(1'b1, 1'b0);
        check("stop_halted", cur, 33'd0);
        stop = 1'b0;
        tick(1'b1, 1'b0);
        check("stop_halt_sticky", cur, 33'd0);
        do_reset();

        // Reset asserted mid-cycle during st T7.
        opcode = 5'b00010;
        for (int k = 1; k <= 7; k++) tick(k < 7, 1'b0);
        check("st_t7_write", cur, MDR_OUT | MEM_WRITE | RUN);
        #2;
        reset_n = 1'b0;
        #1;
        check("st_async_drop", sample(), 33'd0);
        tick(1'b1, 1'b0);
        check("st_reset_held", cur, 33'd0);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        check("st_release_rst", sample(), 33'd0);
        tick(1'b1, 1'b0);
        check("st_refetch_t0", cur, T0V);

        // jal followed by halt.
        measure(5'b10101, 1'b0, 99, 0, n);
        check_int("jal_cycles", n, 5);
        check("jal_t3", trace[3], PC_OUT | GRB | R_IN | RUN);
        check("jal_t4", trace[4], GRA | R_OUT | PC_IN | RUN);
        opcode = HALT;
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        check("halt_t2", cur, MDR_OUT | IR_IN | RUN);
        for (int k = 0; k < 20; k++) begin
            tick(1'b1, 1'b0);
            check($sformatf("halt_hold_%0d", k), cur, 33'd0);
        end

`ifdef CU_ILLEGAL_TRAP_EN
        do_reset();
        check_int("illegal_clear_after_reset", int'(illegal_op), 0);
        opcode = 5'b11110;
        for (int k = 1; k <= 3; k++) tick(1'b1, 1'b0);
        check("illegal_halted", cur, 33'd0);
        check_int("illegal_flag", int'(illegal_op), 1);
        for (int k = 0; k < 3; k++) tick(1'b1, 1'b0);
        check_int("illegal_flag_sticky", int'(illegal_op), 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
